// File: rtl/fma_issue_arbiter.sv
// rtl/fma_issue_arbiter.sv - chain-granular round-robin issue arbiter for the FMA bank with in-order result return
// Optional per-requester perf counters are enabled by defining FMA_ARB_PERF_EN.
module fma_issue_arbiter #(
    parameter int REQ_COUNT  = 2,
    parameter int LINE_WIDTH = 96,
    parameter int WORD_WIDTH = 16,
    parameter int FMA_COUNT  = 2,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [REQ_COUNT-1:0]              req_valid_in,
    input  logic [REQ_COUNT*LINE_WIDTH-1:0]   req_line_in,
    input  logic [REQ_COUNT-1:0]              req_use_new_c_in,
    input  logic [REQ_COUNT-1:0]              req_last_in,
    output logic [REQ_COUNT-1:0]              req_ready_out,
    output logic [LINE_WIDTH-1:0]             fma_abc_out,
    output logic                              fma_valid_out,
    output logic                              fma_c_valid_out,
    input  logic [WORD_WIDTH*FMA_COUNT-1:0]   fma_result_in,
    input  logic                              fma_result_valid_in,
    output logic [REQ_COUNT-1:0]              resp_valid_out,
    output logic [WORD_WIDTH*FMA_COUNT-1:0]   resp_data_out,
    output logic                              err_out
`ifdef FMA_ARB_PERF_EN
    ,
    output logic [REQ_COUNT*16-1:0]           perf_beats_out,
    output logic [15:0]                       perf_stall_out
`endif
);

    localparam int PW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                      r_state, w_state_nxt;
    logic [PW-1:0]               r_owner, r_ptr, w_owner_nxt, w_ptr_nxt;
    logic [PW-1:0]               w_search, w_sel;
    logic                        w_found, w_sel_ok, w_accept, w_pop;
    logic [REQ_COUNT-1:0]        w_ready;
    int                          w_idx;

    logic [AW:0]                 r_count;
    logic [AW-1:0]               r_wr, r_rd;
    logic [PW-1:0]               r_tags [TAG_DEPTH];

    logic [LINE_WIDTH-1:0]       r_abc;
    logic                        r_fma_valid, r_c_valid, r_err;
    logic [REQ_COUNT-1:0]        r_resp_valid;
    logic [WORD_WIDTH*FMA_COUNT-1:0] r_resp_data;

    // Descending scan so the requester closest to r_ptr is assigned last and wins.
    always_comb begin
        w_search = r_ptr;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = REQ_COUNT - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % REQ_COUNT;
            if (req_valid_in[w_idx]) begin
                w_search = PW'(w_idx);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_sel       = w_search;
        w_sel_ok    = w_found;
        if (r_state == S_LOCKED) begin
            w_sel    = r_owner;
            w_sel_ok = 1'b1;
        end
        w_ready  = (w_sel_ok && (r_count < (AW+1)'(TAG_DEPTH))) ? (REQ_COUNT'(1) << w_sel) : '0;
        w_accept = |(w_ready & req_valid_in);
        if (w_accept) begin
            if (req_last_in[w_sel]) begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = (w_sel == PW'(REQ_COUNT - 1)) ? '0 : w_sel + 1'b1;
            end else begin
                w_state_nxt = S_LOCKED;
                w_owner_nxt = w_sel;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign w_pop = fma_result_valid_in && (r_count != '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_abc        <= '0;
            r_fma_valid  <= 1'b0;
            r_c_valid    <= 1'b0;
            r_count      <= '0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_fma_valid <= w_accept;
            r_c_valid   <= w_accept && req_use_new_c_in[w_sel];
            if (w_accept) begin
                r_abc <= req_line_in[int'(w_sel)*LINE_WIDTH +: LINE_WIDTH];
                r_wr  <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_resp_valid <= w_pop ? (REQ_COUNT'(1) << r_tags[r_rd]) : '0;
            r_resp_data  <= fma_result_in;
            if (fma_result_valid_in && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_tags[r_wr] <= w_sel;
        end
    end

    assign req_ready_out   = w_ready & {REQ_COUNT{rst_n_in}};
    assign fma_abc_out     = r_abc;
    assign fma_valid_out   = r_fma_valid;
    assign fma_c_valid_out = r_c_valid;
    assign resp_valid_out  = r_resp_valid;
    assign resp_data_out   = r_resp_data;
    assign err_out         = r_err;

`ifdef FMA_ARB_PERF_EN
    logic [15:0] r_beats [REQ_COUNT];
    logic [15:0] r_stall;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REQ_COUNT; i++) begin
                r_beats[i] <= '0;
            end
            r_stall <= '0;
        end else begin
            if (w_accept && (r_beats[w_sel] != 16'hFFFF)) begin
                r_beats[w_sel] <= r_beats[w_sel] + 16'd1;
            end
            if ((|req_valid_in) && !w_accept) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    always_comb begin
        perf_beats_out = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            perf_beats_out[i*16 +: 16] = r_beats[i];
        end
    end

    assign perf_stall_out = r_stall;
`endif

endmodule

// File: tb/tb_fma_issue_arbiter.sv
// tb/tb_fma_issue_arbiter.sv - directed self-checking bench for fma_issue_arbiter
module tb_fma_issue_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   rv, c, last;
    logic [95:0]  l0, l1;
    logic [191:0] req_line;
    logic [1:0]   ready;
    logic [95:0]  abc;
    logic         fma_valid, c_valid;
    logic [31:0]  res;
    logic         res_v;
    logic [1:0]   resp_valid;
    logic [31:0]  resp_data;
    logic         err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    assign req_line = {l1, l0};

    fma_issue_arbiter dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .req_valid_in       (rv),
        .req_line_in        (req_line),
        .req_use_new_c_in   (c),
        .req_last_in        (last),
        .req_ready_out      (ready),
        .fma_abc_out        (abc),
        .fma_valid_out      (fma_valid),
        .fma_c_valid_out    (c_valid),
        .fma_result_in      (res),
        .fma_result_valid_in(res_v),
        .resp_valid_out     (resp_valid),
        .resp_data_out      (resp_data),
        .err_out            (err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rv = 2'b00; c = 2'b00; last = 2'b00; res_v = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rv = 2'b11; c = 2'b00; last = 2'b00;
        l0 = '0; l1 = '0; res = '0; res_v = 1'b0;
        tick();
        chk("rst_ready", ready, 2'b00);
        chk("rst_fma_valid", fma_valid, 1'b0);
        chk("rst_c_valid", c_valid, 1'b0);
        chk("rst_abc", abc, 96'h0);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // 1: req0 3-beat chain while req1 waits
        rv = 2'b11; c = 2'b11; last = 2'b10;
        l0 = 96'hA1A1_0000_0000_0000_0000_0001; l1 = 96'hB1B1_0000_0000_0000_0000_00B1;
        #4 chk("t1_rdy0", ready, 2'b01);
        tick();
        chk("t1_abc0", abc, 96'hA1A1_0000_0000_0000_0000_0001);
        chk("t1_cv0", c_valid, 1'b1);
        chk("t1_fv0", fma_valid, 1'b1);
        l0 = 96'hA2A2_0000_0000_0000_0000_0002; c = 2'b10;
        #4 chk("t1_rdy1_locked", ready, 2'b01);
        tick();
        chk("t1_abc1", abc, 96'hA2A2_0000_0000_0000_0000_0002);
        chk("t1_cv1", c_valid, 1'b0);
        l0 = 96'hA3A3_0000_0000_0000_0000_0003; last = 2'b11;
        #4 chk("t1_rdy2_locked", ready, 2'b01);
        tick();
        chk("t1_abc2", abc, 96'hA3A3_0000_0000_0000_0000_0003);
        #4 chk("t1_rdy_req1", ready, 2'b10);
        tick();
        chk("t1_abc_req1", abc, 96'hB1B1_0000_0000_0000_0000_00B1);
        chk("t1_cv_req1", c_valid, 1'b1);
        rv = 2'b00;
        tick();
        chk("t1_idle_fv", fma_valid, 1'b0);
        chk("t1_abc_hold", abc, 96'hB1B1_0000_0000_0000_0000_00B1);
        do_reset();

        // 2: single-beat chains alternate, req0 first after reset
        rv = 2'b11; c = 2'b11; last = 2'b11;
        l0 = 96'hC0C0_0000_0000_0000_0000_00C0; l1 = 96'hC1C1_0000_0000_0000_0000_00C1;
        for (int i = 0; i < 4; i++) begin
            #4 chk("t2_rdy", ready, (i % 2 == 0) ? 128'h1 : 128'h2);
            tick();
            chk("t2_abc", abc, (i % 2 == 0) ? {32'h0, l0} : {32'h0, l1});
        end
        rv = 2'b00;
        do_reset();

        // 3: tag FIFO full blocks ready, no same-cycle bypass
        rv = 2'b01; c = 2'b01; last = 2'b01; l0 = 96'hD0;
        for (int i = 0; i < 8; i++) begin
            #4 chk("t3_rdy_fill", ready, 2'b01);
            tick();
        end
        #4 chk("t3_full", ready, 2'b00);
        tick();
        chk("t3_bubble", fma_valid, 1'b0);
        res_v = 1'b1; res = 32'h1234_5678;
        #4 chk("t3_no_bypass", ready, 2'b00);
        tick();
        res_v = 1'b0;
        chk("t3_resp_valid", resp_valid, 2'b01);
        chk("t3_resp_data", resp_data, 32'h1234_5678);
        #4 chk("t3_ready_again", ready, 2'b01);
        rv = 2'b00;
        tick();
        do_reset();

        // 4: responses return to issuing requester in order
        rv = 2'b01; c = 2'b11; last = 2'b11; l0 = 96'hE0; l1 = 96'hE1;
        #4 chk("t4_rdy_a", ready, 2'b01);
        tick();
        rv = 2'b10;
        #4 chk("t4_rdy_b", ready, 2'b10);
        tick();
        rv = 2'b01; l0 = 96'hE2;
        #4 chk("t4_rdy_c", ready, 2'b01);
        tick();
        rv = 2'b00;
        res_v = 1'b1; res = 32'h0400_0800;
        #4 chk("t4_latency", resp_valid, 2'b00);
        tick();
        chk("t4_rv0", resp_valid, 2'b01);
        chk("t4_rd0", resp_data, 32'h0400_0800);
        res = 32'h0400_0801;
        tick();
        chk("t4_rv1", resp_valid, 2'b10);
        chk("t4_rd1", resp_data, 32'h0400_0801);
        res = 32'h0400_0802;
        tick();
        chk("t4_rv2", resp_valid, 2'b01);
        chk("t4_rd2", resp_data, 32'h0400_0802);
        res_v = 1'b0;
        tick();
        chk("t4_rv_done", resp_valid, 2'b00);
        chk("t4_no_err", err, 1'b0);

        // 5: result with empty FIFO sets sticky error
        do_reset();
        res_v = 1'b1; res = 32'hDEAD_BEEF;
        tick();
        res_v = 1'b0;
        chk("t5_err", err, 1'b1);
        chk("t5_no_resp", resp_valid, 2'b00);
        tick();
        tick();
        chk("t5_err_sticky", err, 1'b1);

        // 6: async reset mid-LOCKED chain
        do_reset();
        chk("t6_err_cleared", err, 1'b0);
        rv = 2'b11; c = 2'b01; last = 2'b10;
        l0 = 96'hF0; l1 = 96'hF1;
        #4 chk("t6_rdy0", ready, 2'b01);
        tick();
        chk("t6_fv0", fma_valid, 1'b1);
        l0 = 96'hF2; c = 2'b00;
        #4 chk("t6_locked", ready, 2'b01);
        tick();
        chk("t6_abc1", abc, 96'hF2);
        rv = 2'b10;
        #4 chk("t6_hold", ready, 2'b01);
        tick();
        chk("t6_bubble", fma_valid, 1'b0);
        chk("t6_abc_hold", abc, 96'hF2);
        rv = 2'b11; l0 = 96'hF3;
        tick();
        chk("t6_pre_rst_fv", fma_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_fv", fma_valid, 1'b0);
        chk("t6_async_abc", abc, 96'h0);
        chk("t6_async_ready", ready, 2'b00);
        rv = 2'b10; c = 2'b10; last = 2'b10;
        tick();
        tick();
        rst_n = 1'b1;
        #4 chk("t6_req1_first", ready, 2'b10);
        tick();
        chk("t6_abc_req1", abc, 96'hF1);
        chk("t6_cv_req1", c_valid, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
